// File: rtl/aud_recorder_i2s.sv
`default_nettype none
// ============================================================================
//  Module   : aud_recorder_i2s
//  Purpose  : I2S capture engine that turns ADC serial words into SRAM
//             write strobes, with channel select, capacity limit and
//             pause/stop control. Clocked by BCLK.
//  Revision : 1.0  initial release
// ============================================================================
module aud_recorder_i2s #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 20,
  parameter logic [ADDR_W-1:0]  MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic              o_full,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_len
);

  localparam int                CNT_W       = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  c_cnt_full  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(DATA_W - 1);
  localparam logic [1:0]        c_mode_left = 2'b01;
  localparam logic [1:0]        c_mode_st   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RECORD = 3'd2,
    S_PAUSE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_lrc_d;
  logic [1:0]          r_mode;
  logic                r_chan;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_len;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_full;

  logic                w_edge;
  logic                w_aligned;
  logic                w_sel;
  logic                w_cap_start;
  logic                w_shift_en;
  logic                w_last;
  logic                w_clear;
  logic                w_realign;
  logic [DATA_W-1:0]   w_word;

  assign w_edge     = i_lrc ^ r_lrc_d;
  assign w_shift_en = (r_state == S_RECORD) && !i_stop && !i_pause && !w_edge &&
                      (r_cnt < c_cnt_full);
  assign w_last     = w_shift_en && (r_cnt == c_cnt_last);
  assign w_word     = {r_shift[DATA_W-2:0], i_data};
  assign w_clear    = (r_state == S_IDLE) && (w_next == S_ARM);
  // Stereo resumes on a left word, so an odd address skips its right slot.
  assign w_realign  = (r_state == S_PAUSE) && (w_next == S_ARM) && (r_mode == c_mode_st) &&
                      r_addr[0] && (r_addr != MAX_ADDR);

  always_comb begin
    w_aligned = i_lrc;
    w_sel     = r_chan;
    case (r_mode)
      c_mode_st: begin
        w_aligned = ~i_lrc;
        w_sel     = 1'b1;
      end
      c_mode_left: begin
        w_aligned = ~i_lrc;
        w_sel     = ~r_chan;
      end
      default: begin
        w_aligned = i_lrc;
        w_sel     = r_chan;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cap_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_stop && i_start) w_next = S_ARM;
      end
      S_ARM: begin
        if (i_stop)                   w_next = S_IDLE;
        else if (i_pause)             w_next = S_PAUSE;
        else if (w_edge && w_aligned) begin
          w_next      = S_RECORD;
          w_cap_start = 1'b1;
        end
      end
      S_RECORD: begin
        if (i_stop)                          w_next = S_IDLE;
        else if (r_we && r_addr == MAX_ADDR) w_next = S_DONE;
        else if (i_pause)                    w_next = S_PAUSE;
        else if (w_edge)                     w_cap_start = 1'b1;
      end
      S_PAUSE: begin
        if (i_stop)                   w_next = S_IDLE;
        else if (!i_pause && i_start) w_next = S_ARM;
      end
      S_DONE: begin
        if (i_stop) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrc_d <= 1'b0;
      r_mode  <= 2'b00;
      r_chan  <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_full  <= 1'b0;
    end else begin
      r_lrc_d <= i_lrc;
      r_we    <= w_last && w_sel;
      if (w_last) r_wdata <= w_word;

      if (w_cap_start) begin
        r_cnt   <= '0;
        r_chan  <= i_lrc;
        r_shift <= '0;
      end else if (w_shift_en) begin
        r_cnt   <= r_cnt + 1'b1;
        r_shift <= w_word;
      end

      if (w_clear) begin
        r_addr <= '0;
        r_len  <= '0;
        r_full <= 1'b0;
        r_mode <= i_mode;
      end else if (w_realign) begin
        r_addr <= r_addr + 1'b1;
      end else if (r_we) begin
        r_len <= r_len + 1'b1;
        if (r_addr != MAX_ADDR) r_addr <= r_addr + 1'b1;
      end

      if (r_state == S_RECORD && w_next == S_DONE) r_full <= 1'b1;
    end
  end

  assign o_address = r_addr;
  assign o_data    = r_wdata;
  assign o_we      = r_we;
  assign o_full    = r_full;
  assign o_len     = r_len;
  assign o_busy    = (r_state == S_ARM) || (r_state == S_RECORD);

endmodule
`default_nettype wire

// File: tb/tb_aud_recorder_i2s.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aud_recorder_i2s
//  Purpose  : Directed scoreboard bench for aud_recorder_i2s (DATA_W=16,
//             ADDR_W=4 so the capacity limit is reachable).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aud_recorder_i2s;

  localparam int               DATA_W   = 16;
  localparam int               ADDR_W   = 4;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 4'd15;

  logic              i_clk   = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_lrc   = 1'b0;
  logic              i_data  = 1'b0;
  logic              i_start = 1'b0;
  logic              i_pause = 1'b0;
  logic              i_stop  = 1'b0;
  logic [1:0]        i_mode  = 2'b00;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_we;
  logic              o_full;
  logic              o_busy;
  logic [ADDR_W:0]   o_len;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 i_clk = ~i_clk;

  aud_recorder_i2s #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_lrc    (i_lrc),
    .i_data   (i_data),
    .i_start  (i_start),
    .i_pause  (i_pause),
    .i_stop   (i_stop),
    .i_mode   (i_mode),
    .o_address(o_address),
    .o_data   (o_data),
    .o_we     (o_we),
    .o_full   (o_full),
    .o_busy   (o_busy),
    .o_len    (o_len)
  );

  // Every strobe must match the oldest expected write.
  always @(negedge i_clk) begin
    if (o_we === 1'b1) begin
      wr_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got addr=%0h data=%h want no write", o_address, o_data);
      end else begin
        e = exp_q.pop_front();
        if (o_address !== e.addr || o_data !== e.data) begin
          n_fail++;
          $display("FAIL write got addr=%0h data=%h want addr=%0h data=%h",
                   o_address, o_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic lrc, input logic d, input logic [2:0] ctl);
    @(posedge i_clk);
    #2;
    i_lrc = lrc;
    i_data = d;
    {i_stop, i_pause, i_start} = ctl;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(i_lrc, 1'b0, 3'b000);
  endtask

  // Edge cycle carries a bit opposite to the MSB, then nbits data bits MSB first.
  task automatic slot(input logic ch, input logic [31:0] val, input int nbits,
                      input int ctl_at, input logic [2:0] ctl);
    cyc(ch, ~val[nbits-1], (ctl_at == 0) ? ctl : 3'b000);
    for (int k = 1; k <= nbits; k++)
      cyc(ch, val[nbits-k], (ctl_at == k) ? ctl : 3'b000);
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    slot(1'b0, {16'h0, l}, 16, -1, 3'b000);
    slot(1'b1, {16'h0, r}, 16, -1, 3'b000);
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_we"},   32'(o_we),      32'd0);
    check({tag, "_addr"}, 32'(o_address), 32'd0);
    check({tag, "_data"}, 32'(o_data),    32'd0);
    check({tag, "_full"}, 32'(o_full),    32'd0);
    check({tag, "_busy"}, 32'(o_busy),    32'd0);
    check({tag, "_len"},  32'(o_len),     32'd0);
  endtask

  initial begin
    logic [15:0] w;

    idle(3);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    all_zero("reset");

    // Right only, three frames
    i_mode = 2'b00;
    cyc(i_lrc, 1'b0, 3'b001);
    idle(1);
    @(negedge i_clk);
    check("t1_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < 3; k++) push(ADDR_W'(k), 16'hABCD);
    for (int k = 0; k < 3; k++) frame(16'h1234, 16'hABCD);
    idle(3);
    @(negedge i_clk);
    check("t1_len", 32'(o_len), 32'd3);
    cyc(i_lrc, 1'b0, 3'b100);
    idle(2);
    @(negedge i_clk);
    check("t1_stop_busy", 32'(o_busy), 32'd0);

    // Stereo, start mid right slot
    i_mode = 2'b10;
    slot(1'b0, 32'h1234, 16, -1, 3'b000);
    slot(1'b1, 32'hABCD, 16, 5, 3'b001);
    push(4'd0, 16'h1234); push(4'd1, 16'hABCD);
    push(4'd2, 16'h1234); push(4'd3, 16'hABCD);
    frame(16'h1234, 16'hABCD);
    frame(16'h1234, 16'hABCD);
    idle(3);
    @(negedge i_clk);
    check("t2_len", 32'(o_len), 32'd4);
    cyc(i_lrc, 1'b0, 3'b100);
    idle(2);

    // Left only, 17-bit slots and a 10-bit short slot
    i_mode = 2'b01;
    cyc(i_lrc, 1'b0, 3'b001);
    idle(1);
    push(4'd0, 16'h5A3C);
    push(4'd1, 16'hC3E1);
    slot(1'b1, {15'd0, 16'hFFFF, 1'b1}, 17, -1, 3'b000);
    slot(1'b0, {15'd0, 16'h5A3C, 1'b0}, 17, -1, 3'b000);
    slot(1'b1, {15'd0, 16'h0F0F, 1'b1}, 17, -1, 3'b000);
    slot(1'b0, {22'd0, 10'h2A5}, 10, -1, 3'b000);
    slot(1'b1, {15'd0, 16'h0F0F, 1'b1}, 17, -1, 3'b000);
    slot(1'b0, {15'd0, 16'hC3E1, 1'b1}, 17, -1, 3'b000);
    slot(1'b1, {15'd0, 16'h0F0F, 1'b1}, 17, -1, 3'b000);
    idle(3);
    @(negedge i_clk);
    check("t3_len", 32'(o_len), 32'd2);
    cyc(i_lrc, 1'b0, 3'b100);
    idle(2);

    // Stereo pause after five words, resume on a left word at address 6
    i_mode = 2'b10;
    cyc(i_lrc, 1'b0, 3'b001);
    idle(1);
    push(4'd0, 16'h1111); push(4'd1, 16'h2222); push(4'd2, 16'h3333);
    push(4'd3, 16'h4444); push(4'd4, 16'h5555);
    frame(16'h1111, 16'h2222);
    frame(16'h3333, 16'h4444);
    slot(1'b0, 32'h5555, 16, -1, 3'b000);
    slot(1'b1, 32'h6666, 16, 8, 3'b010);
    idle(2);
    @(negedge i_clk);
    check("t4_len_held", 32'(o_len), 32'd5);
    check("t4_pause_busy", 32'(o_busy), 32'd0);
    push(4'd6, 16'h7777);
    push(4'd7, 16'h8888);
    cyc(i_lrc, 1'b0, 3'b001);
    idle(1);
    @(negedge i_clk);
    check("t4_resume_busy", 32'(o_busy), 32'd1);
    frame(16'h7777, 16'h8888);
    idle(3);
    @(negedge i_clk);
    check("t4_len", 32'(o_len), 32'd7);
    cyc(i_lrc, 1'b0, 3'b100);
    idle(2);

    // Capacity: 16 left writes fill addresses 0..15
    i_mode = 2'b01;
    cyc(i_lrc, 1'b0, 3'b001);
    idle(1);
    for (int k = 0; k < 17; k++) begin
      w = 16'hA000 + 16'(k * 257);
      if (k < 16) push(ADDR_W'(k), w);
      frame(w, 16'h0F0F);
    end
    idle(3);
    @(negedge i_clk);
    check("t5_full", 32'(o_full), 32'd1);
    check("t5_busy", 32'(o_busy), 32'd0);
    check("t5_len", 32'(o_len), 32'd16);
    check("t5_addr_held", 32'(o_address), 32'd15);
    cyc(i_lrc, 1'b0, 3'b100);
    idle(2);
    @(negedge i_clk);
    check("t5_full_after_stop", 32'(o_full), 32'd1);
    cyc(i_lrc, 1'b0, 3'b001);
    idle(2);
    @(negedge i_clk);
    check("t5_restart_full", 32'(o_full), 32'd0);
    check("t5_restart_len", 32'(o_len), 32'd0);
    check("t5_restart_addr", 32'(o_address), 32'd0);
    push(4'd0, 16'h4321);
    frame(16'h4321, 16'h0F0F);
    idle(3);
    @(negedge i_clk);
    check("t5_restart_len1", 32'(o_len), 32'd1);
    cyc(i_lrc, 1'b0, 3'b100);
    idle(2);

    // Stop and pause together go to IDLE (start then clears the length)
    i_mode = 2'b00;
    cyc(i_lrc, 1'b0, 3'b001);
    idle(1);
    push(4'd0, 16'hABCD);
    frame(16'h1234, 16'hABCD);
    slot(1'b0, 32'h1234, 16, -1, 3'b000);
    slot(1'b1, 32'hABCD, 16, 6, 3'b110);
    idle(2);
    @(negedge i_clk);
    check("t6_busy", 32'(o_busy), 32'd0);
    check("t6_len", 32'(o_len), 32'd1);
    cyc(i_lrc, 1'b0, 3'b001);
    idle(2);
    @(negedge i_clk);
    check("t6_idle_restart_len", 32'(o_len), 32'd0);
    push(4'd0, 16'hBEEF);
    frame(16'h1234, 16'hBEEF);
    idle(3);
    @(negedge i_clk);
    check("t6_len1", 32'(o_len), 32'd1);

    // Asynchronous reset mid word
    slot(1'b0, 32'h1234, 16, -1, 3'b000);
    slot(1'b1, 32'hCAFE, 6, -1, 3'b000);
    #1 i_rst_n = 1'b0;
    #1 all_zero("async_rst");
    idle(2);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    frame(16'h1234, 16'hABCD);
    frame(16'h1234, 16'hABCD);
    idle(3);
    @(negedge i_clk);
    check("post_rst_len", 32'(o_len), 32'd0);
    check("post_rst_busy", 32'(o_busy), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
